busdec: RTL

BUSDEC -- requirements
Module: busdec

---
 rtl/busdec.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/busdec.sv
// busdec -- single-master address decoder with per-slot completion handshake.
//
// A master request is decoded against NDEV base addresses. On a hit the block
// latches the slot and the device-local address, then enables that one slot
// until it strobes devack or the wait budget runs out. The result is reported
// to the master as a one-cycle ack (success) or err (unmapped or timeout).
//
// Handshake: req/addr are a request that is only taken in IDLE (busy=0); the
// master must hold req until it sees busy rise (or a response pulse). Each
// accepted request produces exactly one response pulse, ack or err, in DONE.
// Devices see deven[k] held high for the whole wait; devack[k] is a strobe
// that only counts for the currently enabled slot.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous active-high reset
//   req        master request
//   addr       master address (upper bits select slot, low MASK bits local)
//   devack     per-slot completion strobe
//   deven      one-hot device enable (only in WAIT)
//   devaddr    latched device-local address
//   ack        one-cycle success pulse
//   err        one-cycle failure pulse
//   busy       high whenever the FSM is not idle
//   dbg_state  current FSM state encoding (0 idle, 1 wait, 2 done)
module busdec #(
  parameter int                  NDEV    = 4,
  parameter logic [NDEV*32-1:0]  BASES   = {32'h3, 32'h2, 32'h1, 32'h0},
  parameter int                  MASK    = 4,
  parameter int                  TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [31:0]       addr,
  input  logic [NDEV-1:0]   devack,
  output logic [NDEV-1:0]   deven,
  output logic [MASK-1:0]   devaddr,
  output logic              ack,
  output logic              err,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam int SEL_W = (NDEV > 1) ? $clog2(NDEV) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [MASK-1:0]   devaddr_q, devaddr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // Result flag carried into DONE: 1 = report err, 0 = report ack.
  logic              fail_q, fail_d;

  logic              hit;
  logic [SEL_W-1:0]  hit_idx;

  // Slot match. Scanning from the top down means the last assignment comes
  // from the lowest matching index, which is the one that must win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = NDEV - 1; k >= 0; k--) begin
      if ({{MASK{1'b0}}, addr[31:MASK]} == BASES[32*k +: 32]) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(k);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      devaddr_q <= '0;
      cnt_q     <= '0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      devaddr_q <= devaddr_d;
      cnt_q     <= cnt_d;
      fail_q    <= fail_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    devaddr_d = devaddr_q;
    cnt_d     = cnt_q;
    fail_d    = fail_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (hit) begin
            sel_d     = hit_idx;
            devaddr_d = addr[MASK-1:0];
            cnt_d     = '0;
            fail_d    = 1'b0;
            state_d   = S_WAIT;
          end else begin
            // Unmapped: go straight to DONE, no device is ever enabled.
            fail_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_WAIT: begin
        // devack is checked before the budget so a same-cycle ack wins.
        if (devack[sel_q]) begin
          fail_d  = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          fail_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode from registered state only.
  always_comb begin
    deven = '0;
    if (state_q == S_WAIT) begin
      for (int k = 0; k < NDEV; k++) begin
        deven[k] = (sel_q == SEL_W'(k));
      end
    end
  end

  assign devaddr   = devaddr_q;
  assign ack       = (state_q == S_DONE) && !fail_q;
  assign err       = (state_q == S_DONE) && fail_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule
